// File: rtl/seq_multiplier.sv
// seq_multiplier: radix-2 shift-add multiplier, N-bit operands, 2N-bit product.
// Unsigned or two's-complement signed mode; one result N+1 clocks after start.
//
// Handshake: start is sampled only on a rising edge where busy = 0 (state IDLE).
// That edge captures A, B and signed_mode, and busy rises just after it. A start
// seen while busy = 1 is dropped, not queued. done is a one-cycle pulse on the
// edge that writes P, and busy is already 0 in that cycle. Start held high is
// therefore taken again on the very next edge, which gives one result every
// N+2 cycles.
module seq_multiplier #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           start,
  input  logic           signed_mode,
  input  logic [N-1:0]   A,
  input  logic [N-1:0]   B,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] P,
  output logic [1:0]     state_dbg
);

  localparam int W  = 2 * N;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [N-1:0]  ONE_N    = {{(N-1){1'b0}}, 1'b1};
  localparam logic [W-1:0]  ONE_W    = {{(W-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Operation registers. The operands are held as unsigned magnitudes; the sign
  // of the product is kept apart in neg_q and applied once, in FIN.
  logic [N-1:0]  mcand_q;
  logic [N-1:0]  mplier_q;
  logic [W-1:0]  acc_q;
  logic [CW-1:0] cnt_q;
  logic          neg_q;
  logic          mode_q;
  logic [W-1:0]  p_q;
  logic          done_q;

  // Magnitudes of the incoming operands.
  logic          a_neg, b_neg;
  logic [N-1:0]  a_mag, b_mag;
  logic          accept;
  logic          last_step;
  logic [W-1:0]  partial;

  // Magnitudes of the incoming operands. In signed mode a negative value is
  // negated. -2^(N-1) negates to itself, and that bit pattern read as unsigned
  // is exactly 2^(N-1), so no extra bit is needed.
  always_comb begin
    a_neg = signed_mode & A[N-1];
    b_neg = signed_mode & B[N-1];
    a_mag = a_neg ? (~A + ONE_N) : A;
    b_mag = b_neg ? (~B + ONE_N) : B;
  end

  assign accept    = (state_q == IDLE) && start;
  assign last_step = (cnt_q == CNT_LAST);
  // Multiplicand aligned to the bit of the multiplier that is consumed this step.
  assign partial   = W'(mcand_q) << cnt_q;

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: IDLE -> CALC on start, N steps in CALC, then one FIN cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CALC;
      CALC:    if (last_step) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand capture and shift-add iteration.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      mode_q   <= 1'b0;
    end else if (accept) begin
      mcand_q  <= a_mag;
      mplier_q <= b_mag;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= signed_mode & (A[N-1] ^ B[N-1]);
      mode_q   <= signed_mode;
    end else if (state_q == CALC) begin
      if (mplier_q[0]) begin
        acc_q <= acc_q + partial;
      end
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CNT_ONE;
    end
  end

  // Result write and done pulse. A zero magnitude product negates to zero, so
  // the sign correction never produces a negative zero.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      p_q    <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q == FIN) begin
        p_q    <= neg_q ? (~acc_q + ONE_W) : acc_q;
        done_q <= 1'b1;
      end
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign P         = p_q;
  assign state_dbg = state_q;

  // The captured mode is kept for debug visibility only; the result path needs
  // only the sign in neg_q.
  logic mode_unused;
  assign mode_unused = mode_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: one N=8 and one N=4 instance.
// Expected products come from a longint reference model and are queued when a
// start is driven, then popped and compared when done is seen.
module tb_seq_multiplier;

  logic clk = 1'b0;
  logic rstn;

  logic       start8, sm8, busy8, done8;
  logic [7:0] a8, b8;
  logic [15:0] p8;
  logic [1:0] st8;

  logic       start4, sm4, busy4, done4;
  logic [3:0] a4, b4;
  logic [7:0] p4;
  logic [1:0] st4;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  seq_multiplier #(.N(8)) u_dut8 (
    .clk(clk), .rstn(rstn), .start(start8), .signed_mode(sm8),
    .A(a8), .B(b8), .busy(busy8), .done(done8), .P(p8), .state_dbg(st8)
  );

  seq_multiplier #(.N(4)) u_dut4 (
    .clk(clk), .rstn(rstn), .start(start4), .signed_mode(sm4),
    .A(a4), .B(b4), .busy(busy4), .done(done4), .P(p4), .state_dbg(st4)
  );

  // ---------------- reference model ----------------
  function automatic logic [15:0] ref_prod(input int n, input logic [7:0] a,
                                           input logic [7:0] b, input bit sm);
    longint av, bv, pr;
    av = longint'(a);
    bv = longint'(b);
    if (sm && a[n-1]) av = av - (longint'(1) << n);
    if (sm && b[n-1]) bv = bv - (longint'(1) << n);
    pr = av * bv;
    return 16'(pr & ((longint'(1) << (2 * n)) - 1));
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_ops(input int n, input logic [7:0] a, input logic [7:0] b,
                         input bit sm, input bit st);
    if (n == 4) begin
      a4 = a[3:0]; b4 = b[3:0]; sm4 = sm; start4 = st;
    end else begin
      a8 = a; b8 = b; sm8 = sm; start8 = st;
    end
  endtask

  function automatic logic get_done(input int n);
    return (n == 4) ? done4 : done8;
  endfunction

  function automatic logic get_busy(input int n);
    return (n == 4) ? busy4 : busy8;
  endfunction

  function automatic logic [15:0] get_p(input int n);
    return (n == 4) ? {8'h00, p4} : p8;
  endfunction

  // One start pulse on the N=8 instance, then a bounded 14-edge observation.
  // lat is the edge count from the accepted start edge to the first done.
  task automatic run_single(input logic [7:0] a, input logic [7:0] b, input bit sm,
                            output int lat, output int busy_cnt, output int ndone,
                            output logic [15:0] p_done);
    @(posedge clk); #1;
    set_ops(8, a, b, sm, 1'b1);
    exp_q.push_back(ref_prod(8, a, b, sm));
    @(posedge clk); #1;
    set_ops(8, 8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
    lat = -1; ndone = 0; p_done = 'x;
    busy_cnt = busy8 ? 1 : 0;
    for (int i = 1; i <= 14; i++) begin
      @(posedge clk); #1;
      if (busy8) busy_cnt++;
      if (done8) begin
        ndone++;
        if (lat < 0) begin
          lat = i;
          p_done = p8;
        end
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rstn = 1'b0;
    set_ops(8, 8'h00, 8'h00, 1'b0, 1'b0);
    set_ops(4, 8'h00, 8'h00, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({busy8, done8, st8} !== 4'b0) begin
      n_fail++; $display("FAIL reset_ctrl8: got busy=%b done=%b state=%0d, want 0 0 0", busy8, done8, st8);
    end
    n_checks++;
    if (p8 !== 16'h0000) begin
      n_fail++; $display("FAIL reset_p8: got %h, want 0000", p8);
    end
    n_checks++;
    if ({busy4, done4, st4, p4} !== 12'h000) begin
      n_fail++; $display("FAIL reset_n4: got busy=%b done=%b state=%0d P=%h, want all 0", busy4, done4, st4, p4);
    end
    rstn = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0) begin
      n_fail++; $display("FAIL idle_after_reset: got busy=%b done=%b, want 0 0", busy8, done8);
    end
  endtask

  task automatic test_unsigned_max;
    int lat, bc, nd;
    logic [15:0] pd, ex;
    run_single(8'd255, 8'd255, 1'b0, lat, bc, nd, pd);
    ex = exp_q.pop_front();
    n_checks++;
    if (lat !== 9) begin
      n_fail++; $display("FAIL umax_latency: got %0d edges, want 9", lat);
    end
    n_checks++;
    if (bc !== 9) begin
      n_fail++; $display("FAIL umax_busy_cycles: got %0d, want 9", bc);
    end
    n_checks++;
    if (nd !== 1) begin
      n_fail++; $display("FAIL umax_done_count: got %0d, want 1", nd);
    end
    n_checks++;
    if (pd !== ex || pd !== 16'hFE01) begin
      n_fail++; $display("FAIL umax_product: got %h, want %h", pd, ex);
    end
  endtask

  task automatic test_signed;
    int lat, bc, nd;
    logic [15:0] pd, ex;
    run_single(8'h80, 8'h80, 1'b1, lat, bc, nd, pd);
    ex = exp_q.pop_front();
    n_checks++;
    if (pd !== ex || pd !== 16'h4000 || lat !== 9) begin
      n_fail++; $display("FAIL signed_min_min: got P=%h lat=%0d, want %h lat=9", pd, lat, ex);
    end
    run_single(8'hF9, 8'h06, 1'b1, lat, bc, nd, pd);
    ex = exp_q.pop_front();
    n_checks++;
    if (pd !== ex || pd !== 16'hFFD6) begin
      n_fail++; $display("FAIL signed_m7_x6: got %h, want %h", pd, ex);
    end
    // The P register must hold its value after done falls.
    n_checks++;
    if (p8 !== 16'hFFD6) begin
      n_fail++; $display("FAIL p_hold: got %h, want ffd6", p8);
    end
  endtask

  task automatic test_zero;
    int lat, bc, nd;
    logic [15:0] pd, ex;
    run_single(8'd0, 8'd200, 1'b0, lat, bc, nd, pd);
    ex = exp_q.pop_front();
    n_checks++;
    if (pd !== ex || pd !== 16'h0000) begin
      n_fail++; $display("FAIL zero_unsigned: got %h, want %h", pd, ex);
    end
    run_single(8'hFF, 8'h00, 1'b1, lat, bc, nd, pd);
    ex = exp_q.pop_front();
    n_checks++;
    if (pd !== ex || pd !== 16'h0000) begin
      n_fail++; $display("FAIL zero_signed_neg: got %h, want %h", pd, ex);
    end
  endtask

  task automatic test_ignored_start;
    int nd;
    logic [15:0] pd, ex;
    @(posedge clk); #1;
    set_ops(8, 8'd3, 8'd5, 1'b0, 1'b1);
    exp_q.push_back(ref_prod(8, 8'd3, 8'd5, 1'b0));
    @(posedge clk); #1;
    set_ops(8, 8'd3, 8'd5, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    set_ops(8, 8'd9, 8'd9, 1'b0, 1'b1);
    @(posedge clk); #1;
    set_ops(8, 8'd9, 8'd9, 1'b0, 1'b0);
    nd = 0; pd = 'x;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      if (done8) begin
        nd++;
        pd = p8;
      end
    end
    ex = exp_q.pop_front();
    n_checks++;
    if (nd !== 1) begin
      n_fail++; $display("FAIL ignored_start_dones: got %0d, want 1", nd);
    end
    n_checks++;
    if (pd !== ex || pd !== 16'd15) begin
      n_fail++; $display("FAIL ignored_start_product: got %0d, want %0d", pd, ex);
    end
    n_checks++;
    if (busy8 !== 1'b0) begin
      n_fail++; $display("FAIL ignored_start_busy: got %b, want 0", busy8);
    end
  endtask

  task automatic test_reset_mid;
    int nd, lat, bc;
    logic [15:0] pd, ex;
    @(posedge clk); #1;
    set_ops(8, 8'd7, 8'd7, 1'b0, 1'b1);
    @(posedge clk); #1;
    set_ops(8, 8'd7, 8'd7, 1'b0, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    #2;
    rstn = 1'b0;
    #1;
    n_checks++;
    if ({busy8, done8, st8} !== 4'b0 || p8 !== 16'h0000) begin
      n_fail++; $display("FAIL mid_reset_async: got busy=%b done=%b state=%0d P=%h, want all 0", busy8, done8, st8, p8);
    end
    #3;
    rstn = 1'b1;
    nd = 0;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      if (done8) nd++;
    end
    n_checks++;
    if (nd !== 0 || busy8 !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_no_done: got dones=%0d busy=%b, want 0 0", nd, busy8);
    end
    run_single(8'd2, 8'd3, 1'b0, lat, bc, nd, pd);
    ex = exp_q.pop_front();
    n_checks++;
    if (pd !== ex || pd !== 16'd6) begin
      n_fail++; $display("FAIL after_reset_product: got %0d, want %0d", pd, ex);
    end
  endtask

  // Back-to-back random sweep with start held high throughout. Operands are
  // scrambled while busy to show they are captured only at the accepted edge.
  task automatic test_random(input int n);
    logic [7:0] a, b, lim;
    bit sm;
    logic [15:0] ex;
    int ops = 20;
    lim = 8'((1 << n) - 1);
    @(posedge clk); #1;
    a = lim; b = lim; sm = 1'b0;
    set_ops(n, a, b, sm, 1'b1);
    exp_q.push_back(ref_prod(n, a, b, sm));
    for (int op = 0; op < ops; op++) begin
      @(posedge clk); #1;
      n_checks++;
      if (get_busy(n) !== 1'b1 || get_done(n) !== 1'b0) begin
        n_fail++; $display("FAIL rand%0d_accept op%0d: got busy=%b done=%b, want 1 0", n, op, get_busy(n), get_done(n));
      end
      for (int i = 1; i <= n + 1; i++) begin
        if (i <= n) set_ops(n, 8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
        @(posedge clk); #1;
        if (i <= n) begin
          if (get_done(n) !== 1'b0) begin
            n_checks++; n_fail++;
            $display("FAIL rand%0d_early_done op%0d: done at edge %0d, want edge %0d", n, op, i, n + 1);
          end
        end else begin
          ex = exp_q.pop_front();
          n_checks++;
          if (get_done(n) !== 1'b1 || get_p(n) !== ex) begin
            n_fail++; $display("FAIL rand%0d_product op%0d: got done=%b P=%h, want 1 %h", n, op, get_done(n), get_p(n), ex);
          end
        end
      end
      if (op < ops - 1) begin
        a = 8'($urandom_range(0, int'(lim)));
        b = 8'($urandom_range(0, int'(lim)));
        sm = 1'($urandom);
        if (op == 0) begin
          a = 8'(1 << (n - 1)); b = 8'(1 << (n - 1)); sm = 1'b1;
        end
        set_ops(n, a, b, sm, 1'b1);
        exp_q.push_back(ref_prod(n, a, b, sm));
      end else begin
        set_ops(n, 8'h00, 8'h00, 1'b0, 1'b0);
      end
    end
    @(posedge clk); #1;
    n_checks++;
    if (exp_q.size() != 0 || get_busy(n) !== 1'b0) begin
      n_fail++; $display("FAIL rand%0d_drain: got queue=%0d busy=%b, want 0 0", n, exp_q.size(), get_busy(n));
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_unsigned_max();
    test_signed();
    test_zero();
    test_ignored_start();
    test_reset_mid();
    test_random(4);
    test_random(8);
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Parametrised sequential radix-2 shift-add multiplier, the multi-cycle, width-generic successor to the team's combinational 4-bit unsigned multiplier. It accepts two N-bit operands on a start pulse, supports unsigned and two's-complement signed modes, and returns a 2N-bit product after a fixed N+1 cycles with a done pulse. It is intended for datapaths where a full combinational array multiplier is too costly in area.

## Interface
- N, default 8: operand width in bits; legal range N ≥ 2.
- clk  input  1  rising-edge clock.
- rstn  input  1  asynchronous active-low reset.
- start  input  1  request. Sampled only when busy = 0.
- signed_mode  input  1  0 = unsigned, 1 = two's-complement signed. Captured with the operands.
- A  input  N  multiplicand. Captured on the accepted start edge.
- B  input  N  multiplier. Captured on the accepted start edge.
- busy  output  1  high while a multiplication is in progress.
- done  output  1  one-cycle pulse when P becomes valid.
- P  output  2N  product. Held stable until the next result is written.

## Operation
- States:
  - IDLE: waits for start.
  - CALC: runs N iterations.
  - FIN: applies sign correction and writes the result.
- IDLE → CALC on the first edge where start = 1. On that edge:
  - capture signed_mode.
  - capture |A| and |B| as N-bit unsigned magnitudes. In signed mode the magnitude of a negative value is its two's-complement negation; the magnitude of −2^(N−1) is 2^(N−1), which fits in N unsigned bits.
  - capture neg = signed_mode & (A[N−1] ^ B[N−1]).
  - clear the 2N-bit accumulator and the step counter.
- CALC, one step per cycle:
  - if multiplier LSB = 1, add the multiplicand, shifted to the current bit position, into the accumulator.
  - shift the multiplier right by one.
  - increment the counter.
  - after step N (counter = N−1 on entry), go to FIN.
- FIN, single cycle:
  - P ← neg ? (−acc mod 2^2N) : acc.
  - done ← 1.
  - return to IDLE.
- start while busy = 1: ignored. No queuing, and the operands in flight are unaffected.
- A, B and signed_mode may change freely after the accepted start edge.
- Unsigned results lie in 0 … (2^N−1)², so no overflow is possible.
- Signed results lie in −2^(N−1)·(2^(N−1)−1) … 2^(2N−2) and are always representable in 2N bits.
- Zero operand: result is 0 with neg ignored. The block never produces negative zero.

## Timing
- Reset values: state = IDLE, busy = 0, done = 0, P = 0, and all internal registers = 0.
- Reset is asynchronous and takes effect immediately, including mid-CALC or during FIN. The in-flight operation is discarded and no done is produced.
- Let edge k be the accepted start edge:
  - busy = 1 from just after edge k until edge k+N+1.
  - CALC steps occur on edges k+1 … k+N.
  - At edge k+N+1: P is updated, done = 1 and busy = 0.
  - done falls at edge k+N+2.
- Latency is N+1 clocks from accepted start to done. Throughput is one result per N+2 cycles.
- Back-to-back operation: start held high, or reasserted while done = 1, is accepted at edge k+N+2, because busy is already 0 in the done cycle.
- P keeps its previous value throughout a new operation and changes only on the FIN edge.

## Test plan
- N=8, unsigned, A=255, B=255, start for 1 cycle → done exactly 9 edges after the start edge, P=16'hFE01 (65025), busy high for 9 cycles.
- N=8, signed, A=8'h80 (−128), B=8'h80 → P=16'h4000 (16384). Then A=8'hF9 (−7), B=8'h06 → P=16'hFFD6 (−42).
- N=8, unsigned, A=0, B=200 → P=0. Signed A=8'hFF (−1), B=0 → P=0, not 16'hFFFF.
- Start with A=3, B=5. Pulse start with A=9, B=9 at cycle 3 → ignored, P=15, exactly one done.
- Start with A=7, B=7, then assert rstn=0 at cycle 4 → busy, done and P all 0 immediately, and no done after release. Next start with A=2, B=3 → P=6.
- Randomised sweep, both modes, N=4 and N=8, back-to-back starts → every P equals the reference product (signed or unsigned per mode), and done spacing is exactly N+2 cycles.
